wb_mem_requester: RTL and testbench

- Cache-side initiator that drives the memory_interface block's enable/rd_wrt_mem/addr_mem/data_mem_in/done protocol.
- Accepts one line-miss request from the writeback cache controller.
- If the victim line is dirty, it first writes the victim back, then reads the fill line and returns the fill data.
- Only master of the memory_interface port; one transaction in flight.

---
 rtl/wb_mem_requester.sv | 124 ++++++++++++
 tb/tb_wb_mem_requester.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_requester.sv
// Writeback-cache miss requester: optional dirty-victim write, then line fill, over the memory_interface port.
// Define MEM_TIMEOUT_EN to bound each memory wait to TIMEOUT cycles and report resp_err_o.
module wb_mem_requester #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_dirty_i,
  input  logic [ADDR_W-1:0] victim_addr_i,
  input  logic [DATA_W-1:0] victim_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              mem_enable_o,
  output logic              mem_rd_wrt_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i
);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP} state_e;

  state_e            state_q;
  logic              done_q;
  logic              done_evt;
  logic              timeout;
  logic [ADDR_W-1:0] fill_addr_q;

  // Only a rising edge of done completes an access; a held level never does.
  assign done_evt = mem_done_i & ~done_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  logic [7:0] wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == WB_REQ || state_q == FILL_REQ) wait_cnt_q <= '0;
    else if (state_q == WB_WAIT || state_q == FILL_WAIT)   wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  assign timeout = ((wait_cnt_q + 8'd1) == TO_LIMIT) && !done_evt;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      fill_addr_q  <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_rd_wrt_o <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      done_q       <= mem_done_i;
      mem_enable_o <= 1'b0;
      case (state_q)
        IDLE: if (req_valid_i) begin
          req_ready_o  <= 1'b0;
          fill_addr_q  <= req_addr_i;
          mem_enable_o <= 1'b1;
          if (req_dirty_i) begin
            state_q      <= WB_REQ;
            mem_rd_wrt_o <= 1'b1;
            mem_addr_o   <= victim_addr_i;
            mem_wdata_o  <= victim_data_i;
          end else begin
            state_q      <= FILL_REQ;
            mem_rd_wrt_o <= 1'b0;
            mem_addr_o   <= req_addr_i;
          end
        end
        WB_REQ: state_q <= WB_WAIT;
        WB_WAIT: begin
          if (done_evt) begin
            state_q      <= FILL_REQ;
            mem_enable_o <= 1'b1;
            mem_rd_wrt_o <= 1'b0;
            mem_addr_o   <= fill_addr_q;
          end else if (timeout) begin
            // Writeback never completed: skip the fill and report the error.
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_data_o  <= '0;
          end
        end
        FILL_REQ: state_q <= FILL_WAIT;
        FILL_WAIT: begin
          if (done_evt) begin
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_data_o  <= mem_rdata_i;
          end else if (timeout) begin
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_data_o  <= '0;
          end
        end
        RESP: if (resp_ready_i) begin
          state_q      <= IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          req_ready_o  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_mem_requester.sv
// Bench for wb_mem_requester: memory responder plus a line-level reference (address -> expected fill data).
module tb_wb_mem_requester;
  localparam int AW = 14;
  localparam int DW = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_dirty = 1'b0, resp_ready = 1'b0, mem_done = 1'b0;
  logic [AW-1:0] req_addr = '0, victim_addr = '0;
  logic [DW-1:0] victim_data = '0, mem_rdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_enable, mem_rd_wrt;
  logic [DW-1:0] resp_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  int tests = 0, fails = 0, cyc = 0;

  wb_mem_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_dirty_i(req_dirty), .victim_addr_i(victim_addr), .victim_data_i(victim_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .mem_enable_o(mem_enable), .mem_rd_wrt_o(mem_rd_wrt),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_done_i(mem_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {bit wr; logic [AW-1:0] a; logic [DW-1:0] d; int c;} pulse_t;
  pulse_t        plog[$];
  int            dcyc[$];
  logic [DW-1:0] tbmem [0:16383];
  logic [DW-1:0] refm  [0:16383];
  bit            auto_resp = 1, never_done = 0, man_done = 0;
  logic [DW-1:0] man_rdata = '0;
  int            lat = 4;
  bit            en_double = 0, unstable = 0;

  // Memory responder: logs every enable pulse, completes accesses after lat cycles with a one-cycle done.
  initial begin
    int cd, hcnt;
    bit prev_en;
    pulse_t pend;
    cd = 0; hcnt = 0; prev_en = 0;
    pend = '{0, '0, '0, 0};
    for (int i = 0; i < 16384; i++) tbmem[i] = {$urandom, $urandom};
    tbmem[14'h0010] = 64'h0123456789abcdef;
    forever begin
      @(negedge clk);
      if (mem_enable && prev_en) en_double = 1;
      prev_en = mem_enable;
      if (!auto_resp) begin
        mem_done  = man_done;
        mem_rdata = man_rdata;
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) mem_done = 0;
      end
      if (mem_enable) begin
        pend = '{mem_rd_wrt, mem_addr, mem_wdata, cyc};
        plog.push_back(pend);
        if (auto_resp) cd = lat;
      end else if (auto_resp && cd > 0) begin
        if (pend.wr && (mem_addr !== pend.a || mem_wdata !== pend.d || mem_rd_wrt !== 1'b1)) unstable = 1;
        cd--;
        if (cd == 0 && !never_done) begin
          if (pend.wr) tbmem[pend.a] = pend.d;
          else         mem_rdata = tbmem[pend.a];
          mem_done = 1; hcnt = 1;
          dcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rst();
    check("rst_req_ready",  64'(req_ready), 64'(1));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_err",   64'(resp_err), 64'(0));
    check("rst_resp_data",  resp_data, 64'(0));
    check("rst_mem_enable", 64'(mem_enable), 64'(0));
    check("rst_mem_rd_wrt", 64'(mem_rd_wrt), 64'(0));
    check("rst_mem_addr",   64'(mem_addr), 64'(0));
    check("rst_mem_wdata",  mem_wdata, 64'(0));
  endtask

  task automatic send_req(input logic [AW-1:0] a, input bit d, input logic [AW-1:0] va, input logic [DW-1:0] vd);
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin tick(); k++; end
    check("req_ready_before_send", 64'(req_ready), 64'(1));
    req_addr = a; req_dirty = d; victim_addr = va; victim_data = vd; req_valid = 1;
    tick();
    req_valid = 0;
  endtask

  task automatic wait_resp(output int c);
    int k = 0;
    while (resp_valid !== 1'b1 && k < 2000) begin tick(); k++; end
    check("resp_valid_wait", 64'(resp_valid), 64'(1));
    c = cyc;
  endtask

  task automatic wait_pulse(input int n0);
    int k = 0;
    while (plog.size() <= n0 && k < 200) begin tick(); k++; end
    check("enable_pulse_wait", 64'(plog.size() > n0), 64'(1));
  endtask

  // One full miss; the expectation comes from the reference line contents only.
  task automatic run_txn(input logic [AW-1:0] a, input bit d, input logic [AW-1:0] va,
                         input logic [DW-1:0] vd, input int hold, input bit early);
    logic [DW-1:0] exp;
    int n0, d0, rc, np;
    exp = (d && va == a) ? vd : refm[a];
    n0 = plog.size(); d0 = dcyc.size();
    if (early) resp_ready = 1;
    send_req(a, d, va, vd);
    wait_resp(rc);
    check("resp_data", resp_data, exp);
    check("resp_err", 64'(resp_err), 64'(0));
    check("resp_latency", 64'(rc), 64'(dcyc.size() > d0 ? dcyc[$] + 1 : -1));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_valid", 64'(resp_valid), 64'(1));
        check("hold_data", resp_data, exp);
      end
      resp_ready = 1;
    end
    tick();
    resp_ready = 0;
    check("resp_drop", 64'(resp_valid), 64'(0));
    check("req_ready_after", 64'(req_ready), 64'(1));
    np = plog.size() - n0;
    check("pulse_count", 64'(np), 64'(d ? 2 : 1));
    if (np == (d ? 2 : 1)) begin
      if (d) begin
        check("wb_rd_wrt", 64'(plog[n0].wr), 64'(1));
        check("wb_addr", 64'(plog[n0].a), 64'(va));
        check("wb_data", plog[n0].d, vd);
        if (dcyc.size() > d0) check("fill_after_wb", 64'(plog[n0+1].c), 64'(dcyc[d0] + 1));
      end
      check("fill_rd_wrt", 64'(plog[n0+np-1].wr), 64'(0));
      check("fill_addr", 64'(plog[n0+np-1].a), 64'(a));
    end
    if (d) refm[va] = vd;
  endtask

  initial begin
    int n0, rc;
    logic [DW-1:0] exp1, vd2;
    logic [AW-1:0] ra, rva;
    bit rd;

    tick(3);
    rst = 0;
    check_rst();
    for (int i = 0; i < 16384; i++) refm[i] = tbmem[i];

    // Directed misses
    lat = 4;
    run_txn(14'h0010, 0, 14'h0000, 64'h0, 0, 0);
    lat = 3;
    run_txn(14'h0001, 1, 14'h3FFF, 64'hdeadbeefcafef00d, 2, 0);
    run_txn(14'h0005, 1, 14'h0005, 64'h1111, 0, 1);

    // Back-pressure with a competing request held high
    n0 = plog.size();
    exp1 = refm[14'h0030];
    vd2 = {$urandom, $urandom};
    send_req(14'h0030, 0, 14'h0, 64'h0);
    wait_resp(rc);
    check("busy_first_data", resp_data, exp1);
    req_addr = 14'h0031; req_dirty = 1; victim_addr = 14'h0032; victim_data = vd2; req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_valid", 64'(resp_valid), 64'(1));
      check("busy_data", resp_data, exp1);
      check("busy_req_ready", 64'(req_ready), 64'(0));
    end
    check("busy_no_new_pulse", 64'(plog.size() - n0), 64'(1));
    resp_ready = 1;
    tick();
    resp_ready = 0;
    check("busy_handshake_drop", 64'(resp_valid), 64'(0));
    check("busy_idle_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 0;
    check("busy_second_accepted", 64'(req_ready), 64'(0));
    wait_resp(rc);
    check("busy_second_data", resp_data, refm[14'h0031]);
    resp_ready = 1; tick(); resp_ready = 0;
    check("busy_pulses", 64'(plog.size() - n0), 64'(3));
    if (plog.size() - n0 == 3) begin
      check("busy_wb_addr", 64'(plog[n0+1].a), 64'(14'h0032));
      check("busy_fill_addr", 64'(plog[n0+2].a), 64'(14'h0031));
    end
    refm[14'h0032] = vd2;

    // Held and spurious done levels, driven by hand
    auto_resp = 0; man_done = 0;
    tick(2);
    n0 = plog.size();
    send_req(14'h0020, 0, 14'h0, 64'h0);
    wait_pulse(n0);
    tick(2);
    man_rdata = 64'h00000000aaaa5555; man_done = 1;
    wait_resp(rc);
    check("held_first_data", resp_data, 64'h00000000aaaa5555);
    resp_ready = 1; tick(); resp_ready = 0;
    tick(2);
    man_done = 0; tick(2); man_done = 1; tick(3);
    check("idle_done_req_ready", 64'(req_ready), 64'(1));
    check("idle_done_resp_valid", 64'(resp_valid), 64'(0));
    check("idle_done_no_pulse", 64'(plog.size() - n0), 64'(1));
    n0 = plog.size();
    send_req(14'h0021, 0, 14'h0, 64'h0);
    wait_pulse(n0);
    tick(8);
    check("held_done_not_completion", 64'(resp_valid), 64'(0));
    man_rdata = 64'h5a5a5a5a12345678; man_done = 0;
    tick(2);
    man_done = 1;
    wait_resp(rc);
    check("held_second_data", resp_data, 64'h5a5a5a5a12345678);
    resp_ready = 1; tick(); resp_ready = 0;
    man_done = 0; tick(2);
    auto_resp = 1;
    tick(2);

    // Reset while waiting on a fill; the abandoned done must go unnoticed
    lat = 20;
    n0 = plog.size();
    send_req(14'h0040, 0, 14'h0, 64'h0);
    wait_pulse(n0);
    tick(5);
    rst = 1; tick(); rst = 0;
    check_rst();
    for (int i = 0; i < 30; i++) begin
      tick();
      check("post_rst_no_enable", 64'(mem_enable), 64'(0));
      check("post_rst_idle", 64'(req_ready), 64'(1));
    end
    check("post_rst_pulses", 64'(plog.size() - n0), 64'(1));
    lat = 2;
    run_txn(14'h0041, 0, 14'h0, 64'h0, 1, 0);

`ifdef MEM_TIMEOUT_EN
    never_done = 1;
    n0 = plog.size();
    send_req(14'h0050, 0, 14'h0, 64'h0);
    wait_resp(rc);
    if (plog.size() > n0) check("to_latency", 64'(rc - plog[n0].c), 64'(256));
    check("to_err", 64'(resp_err), 64'(1));
    check("to_data", resp_data, 64'(0));
    resp_ready = 1; tick(); resp_ready = 0;
    check("to_err_clear", 64'(resp_err), 64'(0));
    n0 = plog.size();
    send_req(14'h0051, 1, 14'h0052, 64'h77);
    wait_resp(rc);
    check("to_wb_err", 64'(resp_err), 64'(1));
    check("to_wb_no_fill", 64'(plog.size() - n0), 64'(1));
    resp_ready = 1; tick(); resp_ready = 0;
    never_done = 0;
    tick(2);
`endif

    // Randomized misses over a small address window so lines get reused
    for (int i = 0; i < 24; i++) begin
      ra  = 14'($urandom_range(0, 15));
      rd  = 1'($urandom_range(0, 1));
      rva = ($urandom_range(0, 3) == 0) ? ra : 14'($urandom_range(0, 15));
      lat = $urandom_range(1, 6);
      run_txn(ra, rd, rva, {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("enable_single_cycle", 64'(en_double), 64'(0));
    check("wb_fields_stable", 64'(unstable), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
